lcd_fb_arbiter: RTL and testbench

//  Shares one single-port framebuffer BSRAM between the LCD scan-out line fetcher and a host (CPU/loader) port.

---
 rtl/lcd_fb_arbiter.sv | 126 ++++++++++++
 tb/tb_lcd_fb_arbiter.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_fb_arbiter.sv
// Arbiter sharing one single-port framebuffer BSRAM between LCD scan-out and a host port.
// Optional host stall counter: define LCD_FB_ARB_STATS_EN.
module lcd_fb_arbiter #(
  parameter int AW             = 14,
  parameter int DW             = 16,
  parameter int RD_LAT         = 1,
  parameter int MAX_SCAN_BURST = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          scan_req,
  input  logic          scan_urgent,
  input  logic [AW-1:0] scan_addr,
  output logic          scan_gnt,
  output logic          scan_rvalid,
  output logic [DW-1:0] scan_rdata,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          stats_clr,
  output logic [15:0]   host_wait
);

  localparam int         DEPTH     = RD_LAT + 1;
  localparam logic [7:0] BURST_MAX = 8'(MAX_SCAN_BURST);

  logic [7:0]       streak;
  logic [DEPTH-1:0] tag_valid;
  logic [DEPTH-1:0] tag_host;
  logic [DW-1:0]    scan_hold;
  logic [DW-1:0]    host_hold;
  logic             issue_read;

  // Scan wins unless the host has already waited out a full burst and scan is not urgent.
  assign scan_gnt   = scan_req & (~host_req | scan_urgent | (streak < BURST_MAX));
  assign host_gnt   = host_req & ~scan_gnt;
  assign issue_read = scan_gnt | (host_gnt & ~host_we);

  always_ff @(posedge clk) begin
    if (rst) begin
      streak <= 8'd0;
    end else if (!host_req || host_gnt) begin
      streak <= 8'd0;
    end else if (scan_gnt && (streak < BURST_MAX)) begin
      streak <= streak + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_ce    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (scan_gnt) begin
      mem_ce    <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= scan_addr;
      mem_wdata <= '0;
    end else if (host_gnt) begin
      mem_ce    <= 1'b1;
      mem_we    <= host_we;
      mem_addr  <= host_addr;
      mem_wdata <= host_wdata;
    end else begin
      mem_ce <= 1'b0;
      mem_we <= 1'b0;
    end
  end

  // Stage k of the tag pipe describes the access whose grant was k+1 cycles ago.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_valid <= '0;
      tag_host  <= '0;
    end else begin
      tag_valid <= {tag_valid[DEPTH-2:0], issue_read};
      tag_host  <= {tag_host[DEPTH-2:0], host_gnt};
    end
  end

  assign scan_rvalid = tag_valid[RD_LAT] & ~tag_host[RD_LAT];
  assign host_rvalid = tag_valid[RD_LAT] &  tag_host[RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_hold <= '0;
      host_hold <= '0;
    end else begin
      if (scan_rvalid) scan_hold <= mem_rdata;
      if (host_rvalid) host_hold <= mem_rdata;
    end
  end

  // Read data passes straight through on the return cycle and is held afterwards.
  assign scan_rdata = scan_rvalid ? mem_rdata : scan_hold;
  assign host_rdata = host_rvalid ? mem_rdata : host_hold;

`ifdef LCD_FB_ARB_STATS_EN
  logic [15:0] wait_cnt;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      wait_cnt <= 16'h0000;
    end else if (host_req && !host_gnt && (wait_cnt != 16'hFFFF)) begin
      wait_cnt <= wait_cnt + 16'h0001;
    end
  end

  assign host_wait = wait_cnt;
`else
  logic unused_stats_clr;
  assign unused_stats_clr = stats_clr;
  assign host_wait        = 16'h0000;
`endif

endmodule

// File: tb/tb_lcd_fb_arbiter.sv
// Directed self-checking bench for lcd_fb_arbiter with a behavioural BSRAM model.
// Expected host_wait values depend on whether LCD_FB_ARB_STATS_EN is defined.
module tb_lcd_fb_arbiter;

  localparam int AW     = 14;
  localparam int DW     = 16;
  localparam int RD_LAT = 3;
  localparam int MAXB   = 8;

  logic          clk;
  logic          rst;
  logic          scan_req;
  logic          scan_urgent;
  logic [AW-1:0] scan_addr;
  logic          scan_gnt;
  logic          scan_rvalid;
  logic [DW-1:0] scan_rdata;
  logic          host_req;
  logic          host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_ce;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          stats_clr;
  logic [15:0]   host_wait;

  int total = 0;
  int bad   = 0;

  lcd_fb_arbiter #(
    .AW(AW), .DW(DW), .RD_LAT(RD_LAT), .MAX_SCAN_BURST(MAXB)
  ) dut (
    .clk(clk), .rst(rst),
    .scan_req(scan_req), .scan_urgent(scan_urgent), .scan_addr(scan_addr),
    .scan_gnt(scan_gnt), .scan_rvalid(scan_rvalid), .scan_rdata(scan_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt), .host_rvalid(host_rvalid),
    .host_rdata(host_rdata),
    .mem_addr(mem_addr), .mem_ce(mem_ce), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stats_clr(stats_clr), .host_wait(host_wait)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BSRAM model: access sampled on the edge ending the mem_ce cycle, data RD_LAT cycles after mem_ce.
  logic [DW-1:0] mem_model [0:(1<<AW)-1];
  logic [DW-1:0] rd_pipe   [0:RD_LAT-1];

  always @(posedge clk) begin
    if (mem_ce && !mem_we) rd_pipe[0] <= mem_model[mem_addr];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    if (mem_ce && mem_we) mem_model[mem_addr] <= mem_wdata;
  end

  assign mem_rdata = rd_pipe[RD_LAT-1];

  task automatic idle_inputs;
    scan_req    = 1'b0;
    scan_urgent = 1'b0;
    scan_addr   = '0;
    host_req    = 1'b0;
    host_we     = 1'b0;
    host_addr   = '0;
    host_wdata  = '0;
    stats_clr   = 1'b0;
  endtask

  task automatic host_write_once(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    host_req   = 1'b1;
    host_we    = 1'b1;
    host_addr  = a;
    host_wdata = d;
    @(negedge clk);
    idle_inputs();
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ({scan_gnt, host_gnt, scan_rvalid, host_rvalid} !== 4'b0000) begin
      bad++;
      $display("[TB] FAIL reset_flags got=%b want=0000", {scan_gnt, host_gnt, scan_rvalid, host_rvalid});
    end
    total++;
    if ({mem_ce, mem_we} !== 2'b00) begin
      bad++;
      $display("[TB] FAIL reset_mem_ctl got=%b want=00", {mem_ce, mem_we});
    end
    total++;
    if ({mem_addr, mem_wdata} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mem_bus got=%h/%h want=0/0", mem_addr, mem_wdata);
    end
    total++;
    if ({scan_rdata, host_rdata, host_wait} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_data got=%h/%h/%h want=0/0/0", scan_rdata, host_rdata, host_wait);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_host_read;
    host_write_once(14'h0010, 16'hF800);
    @(negedge clk);
    host_req  = 1'b1;
    host_we   = 1'b0;
    host_addr = 14'h0010;
    #1;
    total++;
    if ({scan_gnt, host_gnt} !== 2'b01) begin
      bad++;
      $display("[TB] FAIL hread_gnt got=%b want=01", {scan_gnt, host_gnt});
    end
    @(negedge clk);
    idle_inputs();
    #1;
    total++;
    if ({mem_ce, mem_we, mem_addr} !== {2'b10, 14'h0010}) begin
      bad++;
      $display("[TB] FAIL hread_mem got=ce%b we%b a%h want=ce1 we0 a0010", mem_ce, mem_we, mem_addr);
    end
    for (int k = 2; k <= RD_LAT + 2; k++) begin
      @(negedge clk);
      #1;
      total++;
      if ({scan_rvalid, host_rvalid} !== {1'b0, (k == RD_LAT + 1)}) begin
        bad++;
        $display("[TB] FAIL hread_rvalid k=%0d got=%b want=%b", k, {scan_rvalid, host_rvalid}, {1'b0, (k == RD_LAT + 1)});
      end
      if (k >= RD_LAT + 1) begin
        total++;
        if (host_rdata !== 16'hF800) begin
          bad++;
          $display("[TB] FAIL hread_rdata k=%0d got=%h want=f800", k, host_rdata);
        end
      end
      if (k == 2) begin
        total++;
        if (mem_ce !== 1'b0) begin
          bad++;
          $display("[TB] FAIL hread_ce_idle got=%b want=0", mem_ce);
        end
      end
    end
  endtask

  task automatic test_burst_fairness;
    logic [1:0] exp_g;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      scan_req  = 1'b1;
      scan_addr = 14'h0030;
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = 14'h0020;
      #1;
      exp_g = ((i % (MAXB + 1)) == MAXB) ? 2'b01 : 2'b10;
      total++;
      if ({scan_gnt, host_gnt} !== exp_g) begin
        bad++;
        $display("[TB] FAIL burst_gnt i=%0d got=%b want=%b", i, {scan_gnt, host_gnt}, exp_g);
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_urgent;
    logic [1:0] exp_g;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      scan_req    = 1'b1;
      scan_urgent = (i < 20);
      scan_addr   = 14'h0031;
      host_req    = 1'b1;
      host_we     = 1'b0;
      host_addr   = 14'h0021;
      #1;
      exp_g = (i == 20) ? 2'b01 : 2'b10;
      total++;
      if ({scan_gnt, host_gnt} !== exp_g) begin
        bad++;
        $display("[TB] FAIL urgent_gnt i=%0d got=%b want=%b", i, {scan_gnt, host_gnt}, exp_g);
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [1:0] exp_g;
    logic [1:0] exp_rv;
    host_write_once(14'h0123, 16'h1111);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      idle_inputs();
      case (c)
        0: begin scan_req = 1'b1; scan_addr = 14'h0123; end
        1: begin host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0123; end
        2: begin host_req = 1'b1; host_we = 1'b1; host_addr = 14'h0123; host_wdata = 16'hABCD; end
        3: begin host_req = 1'b1; host_we = 1'b0; host_addr = 14'h0123; end
        default: ;
      endcase
      #1;
      exp_g  = (c == 0) ? 2'b10 : ((c <= 3) ? 2'b01 : 2'b00);
      exp_rv = (c == 4) ? 2'b10 : ((c == 5 || c == 7) ? 2'b01 : 2'b00);
      total++;
      if ({scan_gnt, host_gnt} !== exp_g) begin
        bad++;
        $display("[TB] FAIL b2b_gnt c=%0d got=%b want=%b", c, {scan_gnt, host_gnt}, exp_g);
      end
      total++;
      if ({scan_rvalid, host_rvalid} !== exp_rv) begin
        bad++;
        $display("[TB] FAIL b2b_rvalid c=%0d got=%b want=%b", c, {scan_rvalid, host_rvalid}, exp_rv);
      end
      if (c == 1) begin
        total++;
        if ({mem_ce, mem_we, mem_addr, mem_wdata} !== {2'b10, 14'h0123, 16'h0000}) begin
          bad++;
          $display("[TB] FAIL b2b_scan_mem got=ce%b we%b a%h d%h want=ce1 we0 a0123 d0000", mem_ce, mem_we, mem_addr, mem_wdata);
        end
      end
      if (c == 3) begin
        total++;
        if ({mem_ce, mem_we, mem_wdata} !== {2'b11, 16'hABCD}) begin
          bad++;
          $display("[TB] FAIL b2b_write_mem got=ce%b we%b d%h want=ce1 we1 dabcd", mem_ce, mem_we, mem_wdata);
        end
      end
      if (c == 4) begin
        total++;
        if (scan_rdata !== 16'h1111) begin
          bad++;
          $display("[TB] FAIL b2b_scan_rdata got=%h want=1111", scan_rdata);
        end
      end
      if (c == 5) begin
        total++;
        if (host_rdata !== 16'h1111) begin
          bad++;
          $display("[TB] FAIL b2b_host_rdata1 got=%h want=1111", host_rdata);
        end
      end
      if (c == 7) begin
        total++;
        if (host_rdata !== 16'hABCD) begin
          bad++;
          $display("[TB] FAIL b2b_host_rdata2 got=%h want=abcd", host_rdata);
        end
      end
    end
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_reset_flush;
    logic [1:0] exp_g;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      scan_req  = 1'b1;
      scan_addr = 14'h0040;
      host_req  = 1'b1;
      host_we   = 1'b0;
      host_addr = 14'h0041;
      rst       = (c == 2);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      if (i == 0) begin
        total++;
        if ({mem_ce, mem_we, mem_addr, mem_wdata} !== '0) begin
          bad++;
          $display("[TB] FAIL flush_mem got=ce%b we%b a%h d%h want=all 0", mem_ce, mem_we, mem_addr, mem_wdata);
        end
        total++;
        if ({scan_rdata, host_rdata} !== '0) begin
          bad++;
          $display("[TB] FAIL flush_rdata got=%h/%h want=0/0", scan_rdata, host_rdata);
        end
      end
      if (i < 4) begin
        total++;
        if ({scan_rvalid, host_rvalid} !== 2'b00) begin
          bad++;
          $display("[TB] FAIL flush_rvalid i=%0d got=%b want=00", i, {scan_rvalid, host_rvalid});
        end
      end
      exp_g = (i == MAXB) ? 2'b01 : 2'b10;
      total++;
      if ({scan_gnt, host_gnt} !== exp_g) begin
        bad++;
        $display("[TB] FAIL flush_gnt i=%0d got=%b want=%b", i, {scan_gnt, host_gnt}, exp_g);
      end
    end
    @(negedge clk);
    idle_inputs();
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  task automatic test_stats;
    logic [15:0] exp_w;
    @(negedge clk);
    idle_inputs();
    stats_clr = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      stats_clr   = 1'b0;
      scan_req    = 1'b1;
      scan_urgent = 1'b1;
      host_req    = 1'b1;
      host_we     = 1'b0;
      #1;
      total++;
      if (host_gnt !== 1'b0) begin
        bad++;
        $display("[TB] FAIL stats_blocked i=%0d got=%b want=0", i, host_gnt);
      end
      if (i == 1) begin
        total++;
        if (host_wait !== 16'd0) begin
          bad++;
          $display("[TB] FAIL stats_start got=%0d want=0", host_wait);
        end
      end
    end
    @(negedge clk);
    stats_clr = 1'b1;
    #1;
`ifdef LCD_FB_ARB_STATS_EN
    exp_w = 16'd10;
`else
    exp_w = 16'd0;
`endif
    total++;
    if (host_wait !== exp_w) begin
      bad++;
      $display("[TB] FAIL stats_before_clr got=%0d want=%0d", host_wait, exp_w);
    end
    @(negedge clk);
    stats_clr = 1'b0;
    #1;
    total++;
    if (host_wait !== 16'd0) begin
      bad++;
      $display("[TB] FAIL stats_cleared got=%0d want=0", host_wait);
    end
    @(negedge clk);
    idle_inputs();
    #1;
`ifdef LCD_FB_ARB_STATS_EN
    exp_w = 16'd1;
`else
    exp_w = 16'd0;
`endif
    total++;
    if (host_wait !== exp_w) begin
      bad++;
      $display("[TB] FAIL stats_after_clr got=%0d want=%0d", host_wait, exp_w);
    end
    repeat (RD_LAT + 2) @(negedge clk);
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_host_read();
    test_burst_fairness();
    test_urgent();
    test_back_to_back();
    test_reset_flush();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
